load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding RV32I access against a combinational-read word memory.
// Sub-word stores use read-modify-write. Define MISALIGN_TRAP_EN to reject misaligned H/W accesses.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [1:0]          addr_lo_q;
  logic [15:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wd_q;

  logic                accept;
  logic                legal;
  logic                misaligned;
  logic                bad;
  logic                is_sw;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [31:0]         load_data;
  logic [31:0]         merged;

  assign accept = req_valid && req_ready;
  assign is_sw  = req_we && (req_funct3 == 3'b010);

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
  // Misaligned H/W fall through: lane selection ignores the low address bits.
  assign misaligned = 1'b0;
`endif

  assign bad = !legal || misaligned;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (bad)        state_d = StResp;
          else if (is_sw) state_d = StWrite;
          else            state_d = StRead;
        end
      end
      StRead:  state_d = we_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    lane_b = 8'h00;
    case (addr_lo_q)
      2'd0:    lane_b = mem_rd[7:0];
      2'd1:    lane_b = mem_rd[15:8];
      2'd2:    lane_b = mem_rd[23:16];
      default: lane_b = mem_rd[31:24];
    endcase
    lane_h = addr_lo_q[1] ? mem_rd[31:16] : mem_rd[15:0];

    load_data = mem_rd;
    case (funct3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_data = {24'h000000, lane_b};
      3'b101:  load_data = {16'h0000, lane_h};
      default: load_data = mem_rd;
    endcase

    merged = mem_rd;
    if (funct3_q[0]) merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
    else             merged[{addr_lo_q, 3'b000} +: 8]     = wdata_q[7:0];
  end

  assign req_ready  = (state_q == StIdle);
  assign mem_we     = (state_q == StWrite);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid && err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wd     = mem_wd_q;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      wdata_q    <= 16'h0000;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q      <= req_we;
        funct3_q  <= req_funct3;
        addr_lo_q <= req_addr[1:0];
        wdata_q   <= req_wdata[15:0];
        err_q     <= bad;
        rdata_q   <= 32'h0;
        // Rejected requests leave the memory port untouched.
        if (!bad) begin
          mem_addr_q <= req_addr >> 2;
          if (is_sw) mem_wd_q <= req_wdata;
        end
      end
      if (state_q == StRead) begin
        if (we_q) mem_wd_q <= merged;
        else      rdata_q  <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, random accesses vs. a byte-level model, reset abort.
// Expectations follow MISALIGN_TRAP_EN when it is defined for the build.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wd;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference: byte-lane arithmetic on a word array, independent of any state sequencing.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat, output logic err,
                       output logic [31:0] rdata, output logic [31:0] wword);
    int          widx;
    int          lane;
    int          hlane;
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    bit          legal;
    bit          mis;
    widx  = int'(addr[5:2]);
    lane  = int'(addr[1:0]);
    hlane = int'(addr[1]);
    w     = ref_mem[widx];
    legal = we ? (f3 <= 3'd2) : ((f3 != 3'd3) && (f3 <= 3'd5));
    mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (((f3 == 3'd1) || (f3 == 3'd5)) && addr[0]) || ((f3 == 3'd2) && (addr[1:0] != 2'd0));
`endif
    rdata = 32'h0;
    wword = 32'h0;
    err   = 1'b0;
    lat   = 2;
    if (!legal || mis) begin
      lat = 1;
      err = 1'b1;
    end else if (!we) begin
      b = (w >> (8 * lane)) & 32'hFF;
      h = (w >> (16 * hlane)) & 32'hFFFF;
      case (f3)
        3'd0:    rdata = (b >= 32'd128) ? b - 32'd256 : b;
        3'd1:    rdata = (h >= 32'd32768) ? h - 32'd65536 : h;
        3'd4:    rdata = b;
        3'd5:    rdata = h;
        default: rdata = w;
      endcase
    end else begin
      if (f3 == 3'd2) begin
        wword = wd;
      end else if (f3 == 3'd0) begin
        lat   = 3;
        wword = (w & ~(32'hFF << (8 * lane))) | ((wd & 32'hFF) << (8 * lane));
      end else begin
        lat   = 3;
        wword = (w & ~(32'hFFFF << (16 * hlane))) | ((wd & 32'hFFFF) << (16 * hlane));
      end
      ref_mem[widx] = wword;
    end
  endtask

  // Called on a negedge with the unit idle; returns on a negedge with the unit idle again.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output logic err,
                           output logic [31:0] rdata, output int nwe, output logic [31:0] waddr,
                           output logic [31:0] wdat, output int wcyc);
    lat = 0; err = 1'b0; rdata = 32'h0; nwe = 0; waddr = 32'h0; wdat = 32'h0; wcyc = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_we) begin
        nwe++; waddr = mem_addr; wdat = mem_wd; wcyc = k;
      end
      if (resp_valid) begin
        lat = k; err = resp_err; rdata = resp_rdata;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic run_check(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input int elat,
                           input logic eerr, input logic [31:0] erd, input logic [31:0] eword);
    int          lat;
    int          nwe;
    int          wcyc;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] waddr;
    logic [31:0] wdat;
    bit          wr;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    do_access(we, f3, addr, wd, lat, err, rdata, nwe, waddr, wdat, wcyc);
    wr = we && !eerr;
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".err"}, 32'(err), 32'(eerr));
    check({tag, ".rdata"}, rdata, erd);
    check({tag, ".mem_we_count"}, 32'(nwe), wr ? 32'd1 : 32'd0);
    if (wr) begin
      check({tag, ".mem_addr"}, waddr, addr >> 2);
      check({tag, ".mem_wd"}, wdat, eword);
      check({tag, ".we_cycle"}, 32'(wcyc), 32'(elat - 1));
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wword;
  } vec_t;

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                              int lat, logic err, logic [31:0] rdata, logic [31:0] wword);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.lat = lat; v.err = err; v.rdata = rdata; v.wword = wword;
    return v;
  endfunction

  vec_t        tbl [16];
  int          m_lat;
  logic        m_err;
  logic [31:0] m_rd;
  logic [31:0] m_word;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  int          cnt_we;
  int          cnt_resp;
  logic [31:0] got_rd;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h01010101 * i;
      ref_mem[i] = 32'h01010101 * i;
    end
    mem[2]     = 32'h80818283;
    ref_mem[2] = 32'h80818283;

    tbl[0]  = mk(0, 3'b000, 32'h09, 32'h0, 2, 0, 32'hFFFFFF82, 32'h0);
    tbl[1]  = mk(0, 3'b100, 32'h09, 32'h0, 2, 0, 32'h00000082, 32'h0);
    tbl[2]  = mk(0, 3'b001, 32'h08, 32'h0, 2, 0, 32'hFFFF8283, 32'h0);
    tbl[3]  = mk(0, 3'b101, 32'h0A, 32'h0, 2, 0, 32'h00008081, 32'h0);
    tbl[4]  = mk(1, 3'b001, 32'h0A, 32'h1234ABCD, 3, 0, 32'h0, 32'hABCD8283);
    tbl[5]  = mk(0, 3'b010, 32'h08, 32'h0, 2, 0, 32'hABCD8283, 32'h0);
    tbl[6]  = mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0, 32'hDEADBEEF);
    tbl[7]  = mk(0, 3'b010, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF, 32'h0);
    tbl[8]  = mk(1, 3'b000, 32'h13, 32'h0000005A, 3, 0, 32'h0, 32'h5AADBEEF);
    tbl[9]  = mk(0, 3'b000, 32'h13, 32'h0, 2, 0, 32'h0000005A, 32'h0);
    tbl[10] = mk(0, 3'b011, 32'h10, 32'h0, 1, 1, 32'h0, 32'h0);
    tbl[11] = mk(1, 3'b100, 32'h10, 32'h11223344, 1, 1, 32'h0, 32'h0);
`ifdef MISALIGN_TRAP_EN
    tbl[12] = mk(0, 3'b010, 32'h06, 32'h0, 1, 1, 32'h0, 32'h0);
    tbl[14] = mk(0, 3'b001, 32'h0B, 32'h0, 1, 1, 32'h0, 32'h0);
`else
    tbl[12] = mk(0, 3'b010, 32'h06, 32'h0, 2, 0, 32'h01010101, 32'h0);
    tbl[14] = mk(0, 3'b001, 32'h0B, 32'h0, 2, 0, 32'hFFFFABCD, 32'h0);
`endif
    tbl[13] = mk(0, 3'b110, 32'h00, 32'h0, 1, 1, 32'h0, 32'h0);
    tbl[15] = mk(1, 3'b010, 32'h3C, 32'hCAFEF00D, 2, 0, 32'h0, 32'hCAFEF00D);

    // Reset state, asserted asynchronously before any clock edge.
    #1 rst_in = 1'b1;
    #2;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wd", mem_wd, 32'h0);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'h0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, m_lat, m_err, m_rd, m_word);
      run_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                tbl[i].lat, tbl[i].err, tbl[i].rdata, tbl[i].wword);
    end

    // SB aborted by reset while in READ: no write, no response afterwards.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h04;
    req_wdata = 32'h000000FF;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort.read_addr", mem_addr, 32'h1);
    rst_in = 1'b1;
    #1;
    check("abort.req_ready", 32'(req_ready), 32'd1);
    check("abort.mem_we", 32'(mem_we), 32'd0);
    check("abort.mem_addr", mem_addr, 32'h0);
    check("abort.mem_wd", mem_wd, 32'h0);
    check("abort.resp_valid", 32'(resp_valid), 32'd0);
    check("abort.resp_rdata", resp_rdata, 32'h0);
    check("abort.resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst_in = 1'b0;
    cnt_we = 0; cnt_resp = 0;
    for (int k = 0; k < 6; k++) begin
      if (mem_we) cnt_we++;
      if (resp_valid) cnt_resp++;
      @(negedge clk);
    end
    check("abort.we_after", 32'(cnt_we), 32'd0);
    check("abort.resp_after", 32'(cnt_resp), 32'd0);
    check("abort.ready_after", 32'(req_ready), 32'd1);

    for (int i = 0; i < 150; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = 32'($urandom_range(0, 63));
      r_wd   = $urandom;
      model(r_we, r_f3, r_addr, r_wd, m_lat, m_err, m_rd, m_word);
      run_check($sformatf("rnd%0d", i), r_we, r_f3, r_addr, r_wd, m_lat, m_err, m_rd, m_word);
    end

    // req_valid held high with a store while busy must not start a second access.
    model(1'b0, 3'b010, 32'h10, 32'h0, m_lat, m_err, m_rd, m_word);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BAD0BAD;
    cnt_we = 0; cnt_resp = 0; got_rd = 32'h0;
    for (int k = 0; k < 2; k++) begin
      if (mem_we) cnt_we++;
      if (resp_valid) begin cnt_resp++; got_rd = resp_rdata; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (mem_we) cnt_we++;
      if (resp_valid) cnt_resp++;
      @(negedge clk);
    end
    check("busy.mem_we_count", 32'(cnt_we), 32'd0);
    check("busy.resp_count", 32'(cnt_resp), 32'd1);
    check("busy.rdata", got_rd, m_rd);

    for (int i = 0; i < 16; i++) check($sformatf("mem%0d", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
